// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program-memory loader slice.
//   REG_WIDTH  : instruction/data word width used as the DATA_W default
//   ADDR_WIDTH : program-memory address width used as the ADDR_W default
//   ldState_t  : loader FSM state encoding
// ---------------------------------------------------------------------------
package program_loader_pkg;

   localparam int REG_WIDTH  = 16;
   localparam int ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_RECV  = 2'd1,
      LD_WRITE = 2'd2,
      LD_DONE  = 2'd3
   } ldState_t;

endpackage

// File: rtl/program_loader_counter.sv
// ---------------------------------------------------------------------------
// load_counter
// Word counter for a program load. It counts the words written so far and
// flags when the word currently being written is the last one.
// Ports:
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset, clears the count
//   clear_i    : synchronous clear at the start of a new load
//   inc_i      : advance the count by one
//   length_i   : latched load length the count is compared against
//   count_o    : words written in the current/last load
//   terminal_o : high when count_o + 1 equals length_i
// ---------------------------------------------------------------------------
module load_counter #(
   parameter int CNT_W = 9
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] length_i,
   output logic [CNT_W-1:0] count_o,
   output logic             terminal_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins over increment so a fresh load always starts from zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // The count register itself; reset brings it back to zero.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The counter is one bit wider than the address, so a full 256-word load
   // can reach its terminal value without the sum overflowing.
   assign terminal_o = ((count_q + CNT_W'(1)) == length_i);
   assign count_o    = count_q;

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Writer side of the program-memory interface. It accepts instruction words
// over a valid/ready handshake and writes them to consecutive RAM addresses
// starting at a base address. It also keeps a word count and a running
// checksum so the host can confirm that the load is complete.
// Ports:
//   clk_i, reset_i   : clock and synchronous active-high reset
//   start_i          : begin a load (honoured only when idle)
//   base_addr_i      : first RAM address, latched on start
//   length_i         : number of words 0..2^ADDR_W, latched on start
//   abort_i          : cancel an in-progress load
//   in_data_i        : instruction word from the host
//   in_valid_i       : host word valid
//   in_ready_o       : loader can take a word this cycle
//   mem_addr_o       : RAM write address (qualify with mem_wren_o)
//   mem_data_o       : RAM write data (qualify with mem_wren_o)
//   mem_wren_o       : one-cycle write strobe per word
//   busy_o           : high whenever the loader is not idle
//   done_o           : one-cycle pulse on normal completion
//   word_count_o     : words written in the current/last load
//   checksum_o       : sum of the written words modulo 2^DATA_W
// ---------------------------------------------------------------------------
module program_loader
   import program_loader_pkg::*;
#(
   parameter int DATA_W = REG_WIDTH,
   parameter int ADDR_W = ADDR_WIDTH
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   length_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_wren_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   word_count_o,
   output logic [DATA_W-1:0] checksum_o
);

   ldState_t          state_q;
   logic [ADDR_W-1:0] baseAddr_q;
   logic [ADDR_W:0]   length_q;
   logic [DATA_W-1:0] word_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] checksum_q;

   logic              startAccept;
   logic              writeCommit;
   logic              lastWord;
   logic [ADDR_W:0]   wordCount;

   // A start is only taken when idle; a write only commits if it is not
   // being cancelled in the same cycle, so an aborted word leaves the count
   // and checksum exactly where they were.
   assign startAccept = (state_q == LD_IDLE) && start_i;
   assign writeCommit = (state_q == LD_WRITE) && !abort_i;

   // Word counter shared by the word_count output and the address generator.
   load_counter #(
      .CNT_W (ADDR_W + 1)
   ) u_counter (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clear_i    (startAccept),
      .inc_i      (writeCommit),
      .length_i   (length_q),
      .count_o    (wordCount),
      .terminal_o (lastWord)
   );

   // Main loader FSM together with the word register, the write address and
   // the checksum accumulator. The address and data are captured when a word
   // is accepted, so they are stable for the whole WRITE cycle and simply
   // hold their last values afterwards. The address add is done at the
   // address width, which makes it wrap past the top of memory naturally.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= LD_IDLE;
         baseAddr_q <= '0;
         length_q   <= '0;
         word_q     <= '0;
         memAddr_q  <= '0;
         checksum_q <= '0;
      end else begin
         case (state_q)
            LD_IDLE: begin
               if (start_i) begin
                  baseAddr_q <= base_addr_i;
                  length_q   <= length_i;
                  checksum_q <= '0;
                  state_q    <= (length_i == '0) ? LD_DONE : LD_RECV;
               end
            end
            LD_RECV: begin
               if (abort_i) begin
                  state_q <= LD_IDLE;
               end else if (in_valid_i) begin
                  word_q    <= in_data_i;
                  memAddr_q <= baseAddr_q + wordCount[ADDR_W-1:0];
                  state_q   <= LD_WRITE;
               end
            end
            LD_WRITE: begin
               if (abort_i) begin
                  state_q <= LD_IDLE;
               end else begin
                  checksum_q <= checksum_q + word_q;
                  state_q    <= lastWord ? LD_DONE : LD_RECV;
               end
            end
            LD_DONE: begin
               state_q <= LD_IDLE;
            end
            default: begin
               state_q <= LD_IDLE;
            end
         endcase
      end
   end

   // Status outputs decode straight from the state register. Ready and the
   // write strobe are additionally gated by abort so that a cancelled cycle
   // neither accepts nor writes a word.
   assign in_ready_o   = (state_q == LD_RECV) && !abort_i;
   assign mem_wren_o   = writeCommit;
   assign busy_o       = (state_q != LD_IDLE);
   assign done_o       = (state_q == LD_DONE);
   assign mem_addr_o   = memAddr_q;
   assign mem_data_o   = word_q;
   assign word_count_o = wordCount;
   assign checksum_o   = checksum_q;

endmodule
